// File: rtl/control_unit_mc2_if.sv
// -----------------------------------------------------------------------------
// control_unit_mc2_if
// Bundle between the multicycle control unit and its datapath/memory.
//   master modport (control unit side):
//     inputs : instr[31:0], alu_zero, mem_ready
//     outputs: imm_src[2:0], pc_we, mem_req, mem_addr_src, mem_we, instr_we,
//              rf_we, alu_a_src[1:0], alu_b_src[1:0], alu_ctrl,
//              result_src[1:0], halted, trap_cause[1:0], instret[CNT_W-1:0]
//   slave modport (datapath side): the same signals with directions reversed.
// CNT_W must match the CNT_W of the control unit bound to this interface.
// -----------------------------------------------------------------------------
interface control_unit_mc2_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             alu_zero;
    logic             mem_ready;
    logic [2:0]       imm_src;
    logic             pc_we;
    logic             mem_req;
    logic             mem_addr_src;
    logic             mem_we;
    logic             instr_we;
    logic             rf_we;
    logic [1:0]       alu_a_src;
    logic [1:0]       alu_b_src;
    logic             alu_ctrl;
    logic [1:0]       result_src;
    logic             halted;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        input  instr, alu_zero, mem_ready,
        output imm_src, pc_we, mem_req, mem_addr_src, mem_we, instr_we, rf_we,
               alu_a_src, alu_b_src, alu_ctrl, result_src, halted, trap_cause,
               instret
    );

    modport slave (
        output instr, alu_zero, mem_ready,
        input  imm_src, pc_we, mem_req, mem_addr_src, mem_we, instr_we, rf_we,
               alu_a_src, alu_b_src, alu_ctrl, result_src, halted, trap_cause,
               instret
    );
endinterface

// File: rtl/control_unit_mc2.sv
// -----------------------------------------------------------------------------
// control_unit_mc2
// Multicycle RV32I-style control FSM. Sequences fetch, decode, memory access,
// ALU execution, jumps and branches, counts retired instructions and traps on
// illegal opcodes, SYSTEM opcodes (optional) and memory handshake timeouts.
// Ports:
//   clk  - single clock, all state changes on its rising edge
//   rst  - synchronous active-high reset
//   bus  - control_unit_mc2_if.master: instruction word, ALU zero flag and
//          memory ready in; datapath enables/selects, trap status and the
//          retired-instruction counter out.
// Parameters:
//   CNT_W          - retired-instruction counter width (wraps)
//   MEM_TIMEOUT    - memory wait cycles before a bus trap, 0 disables it
//   EN_U_TYPE      - 1 executes LUI/AUIPC, 0 treats them as illegal
//   TRAP_ON_SYSTEM - 1 traps on SYSTEM opcode, 0 retires it as a NOP
// -----------------------------------------------------------------------------
module control_unit_mc2 #(
    parameter int CNT_W          = 32,
    parameter int MEM_TIMEOUT    = 16,
    parameter int EN_U_TYPE      = 1,
    parameter int TRAP_ON_SYSTEM = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    control_unit_mc2_if.master        bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

    // Wait counter only needs to reach MEM_TIMEOUT-1; it saturates so that a
    // disabled timeout never wraps into a bogus value.
    localparam int              WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_JAL,
        S_JALR,
        S_BR,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]        trap_cause_reg, trap_cause_next;
    logic [CNT_W-1:0]  instret_reg;
    logic              retire;
    logic              in_wait;
    logic              timeout;

    logic [6:0] opcode;
    logic [2:0] funct3;

    logic       pc_we;
    logic       mem_req;
    logic       mem_addr_src;
    logic       mem_we;
    logic       instr_we;
    logic       rf_we;
    logic [1:0] alu_a_src;
    logic [1:0] alu_b_src;
    logic       alu_ctrl;
    logic [1:0] result_src;
    logic [2:0] imm_src;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];

    // Register indices and immediate bits are the datapath's business.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31:15], bus.instr[11:7]};

    // ------------------------------------------------------------------
    // Immediate format decode, independent of FSM state
    // ------------------------------------------------------------------
    always_comb begin
        imm_src = 3'b000;
        case (opcode)
            OP_REG:                                        imm_src = 3'b001;
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: imm_src = 3'b010;
            OP_STORE:                                      imm_src = 3'b011;
            OP_BRANCH:                                     imm_src = 3'b100;
            OP_LUI, OP_AUIPC:                              imm_src = 3'b101;
            OP_JAL:                                        imm_src = 3'b110;
            default:                                       imm_src = 3'b000;
        endcase
    end

    // ------------------------------------------------------------------
    // Timeout: fires in the cycle whose own missing ready would make the
    // wait count equal MEM_TIMEOUT. A ready in that cycle takes precedence
    // because every wait state tests mem_ready before timeout.
    // ------------------------------------------------------------------
    assign in_wait = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                     (state_reg == S_MEM_WRITE);
    assign timeout = (MEM_TIMEOUT > 0) && in_wait && !bus.mem_ready &&
                     (wait_cnt_reg == WAIT_LAST);

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        retire          = 1'b0;
        pc_we           = 1'b0;
        mem_req         = 1'b0;
        mem_addr_src    = 1'b0;
        mem_we          = 1'b0;
        instr_we        = 1'b0;
        rf_we           = 1'b0;
        alu_a_src       = 2'b00;
        alu_b_src       = 2'b00;
        alu_ctrl        = 1'b0;
        result_src      = 2'b00;

        case (state_reg)
            S_FETCH: begin
                // PC + 4 computed and written back as the fetch completes.
                mem_req    = 1'b1;
                alu_a_src  = 2'b00;
                alu_b_src  = 2'b10;
                alu_ctrl   = 1'b1;
                result_src = 2'b10;
                if (bus.mem_ready) begin
                    instr_we   = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next      = S_TRAP;
                    trap_cause_next = CAUSE_BUS;
                end
            end

            S_DECODE: begin
                // Branch target (old PC + imm) precomputed into ALU-out.
                alu_a_src = 2'b01;
                alu_b_src = 2'b01;
                alu_ctrl  = 1'b1;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    OP_REG:            state_next = S_EXEC_R;
                    OP_IMM:            state_next = S_EXEC_I;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_BRANCH:         state_next = S_BR;
                    OP_LUI, OP_AUIPC: begin
                        if (EN_U_TYPE != 0) begin
                            state_next = (opcode == OP_LUI) ? S_LUI : S_AUIPC;
                        end else begin
                            state_next      = S_TRAP;
                            trap_cause_next = CAUSE_ILLEGAL;
                        end
                    end
                    OP_FENCE: begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end
                    OP_SYSTEM: begin
                        if (TRAP_ON_SYSTEM != 0) begin
                            state_next      = S_TRAP;
                            trap_cause_next = CAUSE_SYSTEM;
                        end else begin
                            state_next = S_FETCH;
                            retire     = 1'b1;
                        end
                    end
                    default: begin
                        state_next      = S_TRAP;
                        trap_cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                alu_a_src  = 2'b10;
                alu_b_src  = 2'b01;
                alu_ctrl   = 1'b1;
                // Only loads and stores reach here; bit 5 separates them.
                state_next = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end

            S_MEM_READ: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    state_next      = S_TRAP;
                    trap_cause_next = CAUSE_BUS;
                end
            end

            S_MEM_WRITE: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (timeout) begin
                    state_next      = S_TRAP;
                    trap_cause_next = CAUSE_BUS;
                end
            end

            S_MEM_WB: begin
                result_src = 2'b01;
                rf_we      = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end

            S_EXEC_R: begin
                alu_a_src  = 2'b10;
                alu_b_src  = 2'b00;
                state_next = S_ALU_WB;
            end

            S_EXEC_I: begin
                alu_a_src  = 2'b10;
                alu_b_src  = 2'b01;
                state_next = S_ALU_WB;
            end

            S_JAL: begin
                // Link value old PC + 4; target already in ALU-out from DECODE.
                alu_a_src  = 2'b01;
                alu_b_src  = 2'b10;
                alu_ctrl   = 1'b1;
                pc_we      = 1'b1;
                state_next = S_ALU_WB;
            end

            S_JALR: begin
                alu_a_src  = 2'b10;
                alu_b_src  = 2'b01;
                alu_ctrl   = 1'b1;
                result_src = 2'b10;
                pc_we      = 1'b1;
                state_next = S_ALU_WB;
            end

            S_LUI: begin
                alu_a_src  = 2'b11;
                alu_b_src  = 2'b01;
                alu_ctrl   = 1'b1;
                state_next = S_ALU_WB;
            end

            S_AUIPC: begin
                alu_a_src  = 2'b01;
                alu_b_src  = 2'b01;
                alu_ctrl   = 1'b1;
                state_next = S_ALU_WB;
            end

            S_ALU_WB: begin
                result_src = 2'b00;
                rf_we      = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end

            S_BR: begin
                // funct3[0] inverts the equality sense (BNE/BGE/BGEU),
                // funct3[2] selects the less-than family whose ALU result
                // is nonzero when the condition holds.
                alu_a_src  = 2'b10;
                alu_b_src  = 2'b00;
                pc_we      = bus.alu_zero ^ funct3[0] ^ funct3[2];
                state_next = S_FETCH;
                retire     = 1'b1;
            end

            S_TRAP: begin
                state_next = S_TRAP;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Wait counter restarts whenever the state changes.
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = '0;
        end else if (in_wait && !bus.mem_ready && (wait_cnt_reg != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_FETCH;
            wait_cnt_reg   <= '0;
            trap_cause_reg <= 2'b00;
            instret_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            trap_cause_reg <= trap_cause_next;
            if (retire) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.imm_src      = imm_src;
    assign bus.pc_we        = pc_we;
    assign bus.mem_req      = mem_req;
    assign bus.mem_addr_src = mem_addr_src;
    assign bus.mem_we       = mem_we;
    assign bus.instr_we     = instr_we;
    assign bus.rf_we        = rf_we;
    assign bus.alu_a_src    = alu_a_src;
    assign bus.alu_b_src    = alu_b_src;
    assign bus.alu_ctrl     = alu_ctrl;
    assign bus.result_src   = result_src;
    assign bus.halted       = (state_reg == S_TRAP);
    assign bus.trap_cause   = trap_cause_reg;
    assign bus.instret      = instret_reg;

endmodule

// File: tb/tb_control_unit_mc2.sv
// -----------------------------------------------------------------------------
// tb_control_unit_mc2
// Directed bench for control_unit_mc2 (CNT_W=2, MEM_TIMEOUT=4). The stimulus
// process drives one cycle at a time and queues the expected control word for
// that cycle; a monitor on the falling edge pops each expectation and compares
// it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_control_unit_mc2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_unit_mc2_if #(.CNT_W(2)) bus ();

    control_unit_mc2 #(
        .CNT_W          (2),
        .MEM_TIMEOUT    (4),
        .EN_U_TYPE      (1),
        .TRAP_ON_SYSTEM (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] imm;
        logic       pc_we;
        logic       mem_req;
        logic       addr_src;
        logic       mem_we;
        logic       instr_we;
        logic       rf_we;
        logic [1:0] a_src;
        logic [1:0] b_src;
        logic       alu_ctrl;
        logic [1:0] res_src;
        logic       halted;
        logic [1:0] cause;
        logic [1:0] instret;
    } ctl_t;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    ctl_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_ir = 0;

    // Hand-written control word for each visible phase.
    function automatic ctl_t ex(input string ph, input logic [2:0] imm, input int ir);
        ctl_t e;
        e         = '0;
        e.imm     = imm;
        e.instret = ir[1:0];
        case (ph)
            "FW":  begin e.mem_req = 1; e.b_src = 2'b10; e.alu_ctrl = 1; e.res_src = 2'b10; end
            "FG":  begin e.mem_req = 1; e.b_src = 2'b10; e.alu_ctrl = 1; e.res_src = 2'b10;
                         e.instr_we = 1; e.pc_we = 1; end
            "DEC": begin e.a_src = 2'b01; e.b_src = 2'b01; e.alu_ctrl = 1; end
            "MA":  begin e.a_src = 2'b10; e.b_src = 2'b01; e.alu_ctrl = 1; end
            "MR":  begin e.mem_req = 1; e.addr_src = 1; end
            "MW":  begin e.mem_req = 1; e.addr_src = 1; e.mem_we = 1; end
            "MWB": begin e.res_src = 2'b01; e.rf_we = 1; end
            "XR":  begin e.a_src = 2'b10; e.b_src = 2'b00; end
            "XI":  begin e.a_src = 2'b10; e.b_src = 2'b01; end
            "JAL": begin e.a_src = 2'b01; e.b_src = 2'b10; e.alu_ctrl = 1; e.pc_we = 1; end
            "LUI": begin e.a_src = 2'b11; e.b_src = 2'b01; e.alu_ctrl = 1; end
            "AWB": begin e.res_src = 2'b00; e.rf_we = 1; end
            "BT":  begin e.a_src = 2'b10; e.pc_we = 1; end
            "BN":  begin e.a_src = 2'b10; end
            "T01": begin e.halted = 1; e.cause = 2'b01; end
            "T10": begin e.halted = 1; e.cause = 2'b10; end
            "T11": begin e.halted = 1; e.cause = 2'b11; end
            default: e = '1;
        endcase
        return e;
    endfunction

    // Queue this cycle's expectation, then advance to just after the next edge.
    task automatic step(input string tag, input string ph, input logic [2:0] imm);
        exp_q.push_back(ex(ph, imm, exp_ir));
        name_q.push_back({tag, "/", ph});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] ins, input logic [2:0] imm);
        bus.instr     = ins;
        bus.mem_ready = 1'b1;
        step(tag, "FG", imm);
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_ir = 0;
    endtask

    // Monitor: compare the DUT's control word against each queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e;
            ctl_t  g;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g.imm      = bus.imm_src;
            g.pc_we    = bus.pc_we;
            g.mem_req  = bus.mem_req;
            g.addr_src = bus.mem_addr_src;
            g.mem_we   = bus.mem_we;
            g.instr_we = bus.instr_we;
            g.rf_we    = bus.rf_we;
            g.a_src    = bus.alu_a_src;
            g.b_src    = bus.alu_b_src;
            g.alu_ctrl = bus.alu_ctrl;
            g.res_src  = bus.result_src;
            g.halted   = bus.halted;
            g.cause    = bus.trap_cause;
            g.instret  = bus.instret;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", n, g, e);
            end else begin
                $display("ok   %s: %b", n, g);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.instr     = 32'h0;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: FETCH waiting, counter zero.
        bus.instr = I_ADDI;
        step("rst", "FW", 3'b010);

        // ADDI, ready immediately.
        fetch("addi", I_ADDI, 3'b010);
        step("addi", "DEC", 3'b010);
        step("addi", "XI", 3'b010);
        step("addi", "AWB", 3'b010);
        exp_ir++;

        // LW with three wait cycles in MEM_READ.
        fetch("lw", I_LW, 3'b010);
        step("lw", "DEC", 3'b010);
        step("lw", "MA", 3'b010);
        repeat (3) step("lw", "MR", 3'b010);
        bus.mem_ready = 1'b1;
        step("lw", "MR", 3'b010);
        bus.mem_ready = 1'b0;
        step("lw", "MWB", 3'b010);
        exp_ir++;

        // SW, ready at once.
        fetch("sw", I_SW, 3'b011);
        step("sw", "DEC", 3'b011);
        step("sw", "MA", 3'b011);
        bus.mem_ready = 1'b1;
        step("sw", "MW", 3'b011);
        bus.mem_ready = 1'b0;
        exp_ir++;

        // BNE taken (alu_zero=0) then not taken (alu_zero=1).
        fetch("bne_t", I_BNE, 3'b100);
        step("bne_t", "DEC", 3'b100);
        bus.alu_zero = 1'b0;
        step("bne_t", "BT", 3'b100);
        exp_ir++;
        fetch("bne_n", I_BNE, 3'b100);
        step("bne_n", "DEC", 3'b100);
        bus.alu_zero = 1'b1;
        step("bne_n", "BN", 3'b100);
        bus.alu_zero = 1'b0;
        exp_ir++;

        // Five retired on a 2-bit counter: instret reads 1 here.
        // Ready arrives on the 4th FETCH cycle: handshake beats timeout.
        bus.instr = I_ADD;
        repeat (3) step("add_w", "FW", 3'b001);
        fetch("add", I_ADD, 3'b001);
        step("add", "DEC", 3'b001);
        step("add", "XR", 3'b001);
        step("add", "AWB", 3'b001);
        exp_ir++;

        fetch("jal", I_JAL, 3'b110);
        step("jal", "DEC", 3'b110);
        step("jal", "JAL", 3'b110);
        step("jal", "AWB", 3'b110);
        exp_ir++;

        fetch("lui", I_LUI, 3'b101);
        step("lui", "DEC", 3'b101);
        step("lui", "LUI", 3'b101);
        step("lui", "AWB", 3'b101);
        exp_ir++;

        // FETCH timeout: four cycles without ready, then bus trap held.
        bus.instr     = I_ADDI;
        bus.mem_ready = 1'b0;
        repeat (4) step("tmo", "FW", 3'b010);
        step("tmo", "T10", 3'b010);
        bus.mem_ready = 1'b1;
        step("tmo", "T10", 3'b010);
        bus.alu_zero = 1'b1;
        step("tmo", "T10", 3'b010);
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        do_reset();
        step("tmo_rst", "FW", 3'b010);

        // Illegal opcode.
        fetch("ill", I_ILL, 3'b000);
        step("ill", "DEC", 3'b000);
        bus.mem_ready = 1'b1;
        step("ill", "T01", 3'b000);
        bus.alu_zero = 1'b1;
        step("ill", "T01", 3'b000);
        step("ill", "T01", 3'b000);
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        do_reset();

        // SYSTEM opcode traps.
        fetch("ecall", I_ECALL, 3'b010);
        step("ecall", "DEC", 3'b010);
        step("ecall", "T11", 3'b010);
        step("ecall", "T11", 3'b010);
        do_reset();

        // Reset in the middle of a store wait.
        fetch("addi2", I_ADDI, 3'b010);
        step("addi2", "DEC", 3'b010);
        step("addi2", "XI", 3'b010);
        step("addi2", "AWB", 3'b010);
        exp_ir++;
        fetch("sw_rst", I_SW, 3'b011);
        step("sw_rst", "DEC", 3'b011);
        step("sw_rst", "MA", 3'b011);
        step("sw_rst", "MW", 3'b011);
        rst = 1'b1;
        step("sw_rst", "MW", 3'b011);
        rst    = 1'b0;
        exp_ir = 0;
        step("sw_rst", "FW", 3'b011);
        fetch("sw_rst", I_SW, 3'b011);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit_mc2.md
CONTROL_UNIT_MC2 -- requirements
Module: control_unit_mc2

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of the retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of memory wait cycles before a bus trap; a value of 0 disables the timeout.
REQ-003 SHALL have parameter EN_U_TYPE, default 1, which when 1 executes LUI/AUIPC and when 0 treats them as illegal.
REQ-004 SHALL have parameter TRAP_ON_SYSTEM, default 1, which when 1 traps on opcode 1110011 and when 0 treats it as a NOP.
REQ-005 SHALL have ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- instr  in  32  the latched instruction word.
- alu_zero  in  1  the ALU zero flag.
- mem_ready  in  1  memory completion strobe for the current request.
- imm_src  out  3  immediate format: 000 unknown, 001 R, 010 I, 011 S, 100 B, 101 U, 110 J.
- pc_we  out  1  PC write enable.
- mem_req  out  1  memory request valid.
- mem_addr_src  out  1  memory address select: 0 PC, 1 ALU-out register.
- mem_we  out  1  memory write enable.
- instr_we  out  1  instruction register write enable.
- rf_we  out  1  register file write enable.
- alu_a_src  out  2  ALU operand A: 00 PC, 01 old PC, 10 rs1, 11 zero.
- alu_b_src  out  2  ALU operand B: 00 rs2, 01 imm, 10 constant 4.
- alu_ctrl  out  1  1 forces ADD; 0 decodes the ALU operation from funct3/funct7.
- result_src  out  2  result select: 00 ALU-out register, 01 memory data, 10 direct ALU result.
- halted  out  1  sticky trap indication.
- trap_cause  out  2  trap reason: 00 none, 01 illegal, 10 bus timeout, 11 system.
- instret  out  CNT_W  count of retired instructions.

Function
REQ-006 imm_src SHALL be a combinational decode of instr[6:0]:
- R for 0110011.
- I for 0010011, 0000011, 1100111, 0001111 and 1110011.
- S for 0100011.
- B for 1100011.
- U for 0110111 and 0010111.
- J for 1101111.
- Unknown (000) otherwise.
REQ-007 The FSM SHALL have the states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, JAL, JALR, BR, LUI, AUIPC and TRAP.
REQ-008 FETCH SHALL drive mem_req=1, mem_addr_src=0, alu_a_src=00, alu_b_src=10, alu_ctrl=1 and result_src=10; it SHALL assert instr_we=1 and pc_we=1 only in the cycle mem_ready=1, then go to DECODE, and otherwise stay in FETCH.
REQ-009 DECODE SHALL drive a=01, b=01, alu_ctrl=1 and then branch on opcode:
- load/store -> MEM_ADDR.
- 0110011 -> EXEC_R.
- 0010011 -> EXEC_I.
- 1101111 -> JAL.
- 1100111 -> JALR.
- 1100011 -> BR.
- 0110111 -> LUI and 0010111 -> AUIPC, if EN_U_TYPE=1.
- 0001111 -> FETCH (retire).
- 1110011 -> TRAP with cause 11 if TRAP_ON_SYSTEM=1, else FETCH (retire).
- Anything else -> TRAP with cause 01.
REQ-010 MEM_ADDR SHALL drive a=10, b=01, alu_ctrl=1, then go to MEM_READ (load) or MEM_WRITE (store).
REQ-011 MEM_READ SHALL drive mem_req=1 and mem_addr_src=1, and go to MEM_WB when mem_ready=1.
REQ-012 MEM_WRITE SHALL drive mem_req=1, mem_addr_src=1 and mem_we=1, and go to FETCH (retire) when mem_ready=1.
REQ-013 MEM_WB SHALL drive result_src=01 and rf_we=1, then go to FETCH (retire).
REQ-014 EXEC_R SHALL drive a=10, b=00, alu_ctrl=0 for one cycle, then go to ALU_WB.
REQ-015 EXEC_I SHALL drive a=10, b=01, alu_ctrl=0 for one cycle, then go to ALU_WB.
REQ-016 JAL SHALL drive a=01, b=10, alu_ctrl=1 and pc_we=1, then go to ALU_WB.
REQ-017 JALR SHALL drive a=10, b=01, alu_ctrl=1, result_src=10 and pc_we=1, then go to ALU_WB.
REQ-018 LUI SHALL drive a=11, b=01, alu_ctrl=1, then go to ALU_WB.
REQ-019 AUIPC SHALL drive a=01, b=01, alu_ctrl=1, then go to ALU_WB.
REQ-020 ALU_WB SHALL drive result_src=00 and rf_we=1, then go to FETCH (retire).
REQ-021 BR SHALL drive a=10, b=00, alu_ctrl=0 and pc_we=(alu_zero XOR funct3[0] XOR funct3[2]), then go to FETCH (retire).
REQ-022 Every output not listed for a state SHALL be 0 in that state.
REQ-023 In MEM_READ, MEM_WRITE and FETCH, a wait counter SHALL count the consecutive cycles with mem_ready=0 and SHALL clear on state entry.
REQ-024 If MEM_TIMEOUT>0 and the wait counter reaches MEM_TIMEOUT, the FSM SHALL go to TRAP with cause 10; if mem_ready=1 arrives in that same cycle, the handshake wins and no trap occurs.
REQ-025 TRAP SHALL hold halted=1 and keep trap_cause, SHALL drive all enables and mem_req to 0, and SHALL be left only by reset.
REQ-026 instret SHALL increment by 1 on each retire edge, SHALL wrap from 2^CNT_W-1 to 0, and SHALL not increment on a trap.
REQ-027 No transition SHALL depend on alu_zero.

Reset
REQ-028 With rst=1 at a clock edge, the state SHALL become FETCH, instret 0, halted 0, trap_cause 00 and the wait counter 0.
REQ-029 rst SHALL take priority over every transition, including during a memory wait and in TRAP.
REQ-030 While in FETCH after reset, outputs SHALL follow REQ-008, with mem_req=1.

Verification
REQ-031 The bench SHALL cover: ADDI with mem_ready tied to 1 -> FETCH, DECODE, EXEC_I, ALU_WB; rf_we=1 in cycle 4; instret=1.
REQ-032 The bench SHALL cover: LW with mem_ready delayed by 3 cycles in MEM_READ -> mem_req held 4 cycles, then MEM_WB with result_src=01.
REQ-033 The bench SHALL cover: BNE (funct3=001) with alu_zero=0 -> pc_we=1 in BR; with alu_zero=1 -> pc_we=0.
REQ-034 The bench SHALL cover: opcode 1111111 -> TRAP, halted=1, trap_cause=01, all enables 0 until rst.
REQ-035 The bench SHALL cover: MEM_TIMEOUT=4 with mem_ready held at 0 during FETCH -> TRAP with cause 10 after 4 wait cycles; with mem_ready=1 on the 4th cycle -> DECODE instead.
REQ-036 The bench SHALL cover: CNT_W=2 with 5 retired instructions -> instret=1; rst asserted mid-MEM_WRITE -> FETCH next cycle with mem_we=0.
